// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Word-addressed memory target on the responder side of the CPU memory
//   request interface. It accepts one request at a time over a valid/ready
//   handshake. After a fixed LATENCY it returns either the read data or, for a
//   write, the written word as an echo. The response is held until the CPU
//   accepts it.
//
// Parameters
//   DATA_W       data width in bits (one word on a byte-addressed bus)
//   DEPTH_WORDS  storage depth in words (power of two)
//   LATENCY      cycles from request accept to resp_valid (>= 1)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous, active-high reset
//   req_valid   request present
//   req_ready   responder can accept a request (IDLE and not in reset)
//   req_wr      1 = write, 0 = read
//   req_addr    byte address; bits [log2(DEPTH_WORDS)+1:2] select the word
//   req_wdata   write data (full word)
//   resp_valid  response present
//   resp_ready  CPU accepts the response
//   resp_rdata  read data, or the echoed write word
//   resp_err    misaligned access flag
//   busy        a transaction is outstanding
//
// Build option
//   MEM_ALIGN_CHECK_EN: when defined, a request with req_addr[1:0] != 0 still
//   completes with the normal latency, but it does not touch storage. It
//   responds with resp_err = 1 and resp_rdata = 0. When undefined, resp_err
//   is always 0 and the low address bits are ignored.
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              wr_q;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   logic              accept;
   logic              acc_now;
   logic              acc_wr;
   logic [31:0]       acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [AW-1:0]     acc_idx;
   logic              acc_mis;
   logic              unused_addr_bits;

   assign req_ready  = (state == IDLE) && !rst;
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   assign accept = req_ready && req_valid;

   // With LATENCY == 1 the access happens on the accept edge, so the live
   // request inputs are used. Otherwise the latched copy is used on the edge
   // that ends the last WAIT cycle.
   assign acc_now   = (LATENCY == 1) ? accept
                                     : ((state == WAIT) && (cnt == CW'(1)) && !rst);
   assign acc_wr    = (LATENCY == 1) ? req_wr    : wr_q;
   assign acc_addr  = (LATENCY == 1) ? req_addr  : addr_q;
   assign acc_wdata = (LATENCY == 1) ? req_wdata : wdata_q;
   assign acc_idx   = acc_addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
   assign acc_mis = |acc_addr[1:0];
`else
   assign acc_mis = 1'b0;
`endif

   // The upper address bits wrap, and the low bits are only used by the
   // alignment check.
   assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};

   // Request capture (data path, no reset)
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= req_wr;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Storage write: only on the access edge, never for a misaligned request
   always_ff @(posedge clk) begin
      if (acc_now && acc_wr && !acc_mis) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   // Control FSM and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cnt   <= CW'(LATENCY - 1);
                  state <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // The response is only updated on the access edge, so it stays stable
         // while the CPU applies backpressure.
         if (acc_now) begin
            resp_err <= acc_mis;
            if (acc_mis) begin
               resp_rdata <= '0;
            end else if (acc_wr) begin
               resp_rdata <= acc_wdata;
            end else begin
               resp_rdata <= mem[acc_idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. Two instances share the request bus:
//   u_dut2 (LATENCY = 2) and u_dut4 (LATENCY = 4). 'sel' steers req_valid and
//   resp_ready to one of them and selects which outputs are observed.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        req_valid;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_ready;

   logic        rr2, rv2, er2, bz2;
   logic [31:0] rd2;
   logic        rr4, rv4, er4, bz4;
   logic [31:0] rd4;

   logic        req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid & ~sel),
      .req_ready  (rr2),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (rv2),
      .resp_ready (resp_ready & ~sel),
      .resp_rdata (rd2),
      .resp_err   (er2),
      .busy       (bz2)
   );

   mem_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid & sel),
      .req_ready  (rr4),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (rv4),
      .resp_ready (resp_ready & sel),
      .resp_rdata (rd4),
      .resp_err   (er4),
      .busy       (bz4)
   );

   assign req_ready  = sel ? rr4 : rr2;
   assign resp_valid = sel ? rv4 : rv2;
   assign resp_err   = sel ? er4 : er2;
   assign busy       = sel ? bz4 : bz2;
   assign resp_rdata = sel ? rd4 : rd2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full transaction. While the request is outstanding, the request
   // inputs carry a conflicting junk request, which the DUT must ignore.
   task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input int hold,
                       input logic [31:0] exp_d, input logic exp_e, input string tag);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      #1;
      check({tag, "_ready_idle"}, req_ready, 1);
      @(posedge clk); #1;
      req_wr    = ~wr;
      req_addr  = addr ^ 32'h4;
      req_wdata = ~wdata;
      for (int i = 1; i < lat; i++) begin
         check({tag, "_vld_wait"}, resp_valid, 0);
         check({tag, "_busy_wait"}, busy, 1);
         @(posedge clk); #1;
      end
      check({tag, "_vld"}, resp_valid, 1);
      check({tag, "_rdata"}, resp_rdata, exp_d);
      check({tag, "_err"}, resp_err, exp_e);
      check({tag, "_ready_resp"}, req_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_vld_hold"}, resp_valid, 1);
         check({tag, "_rdata_hold"}, resp_rdata, exp_d);
         check({tag, "_ready_hold"}, req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      #1;
      check({tag, "_vld_done"}, resp_valid, 0);
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_ready_done"}, req_ready, 1);
   endtask

   // Accept a write, then pulse rst in the first WAIT cycle.
   task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, input string tag);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ready"}, req_ready, 1);
      for (int i = 0; i < lat + 1; i++) begin
         check({tag, "_no_resp"}, resp_valid, 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      sel        = 1'b0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;

      // Reset held for two cycles
      #1;
      check("rst_ready_early", req_ready, 0);
      @(posedge clk); #1;
      check("rst_ready", req_ready, 0);
      check("rst_vld", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_err", resp_err, 0);
      @(posedge clk); #1;
      check("rst_ready2", req_ready, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", req_ready, 1);
      check("post_rst_vld", resp_valid, 0);
      @(posedge clk); #1;

      // Write then read back
      xact(1'b1, 32'h10, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 1'b0, "wr10");
      xact(1'b0, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 1'b0, "rd10");

      // Backpressure for three cycles
      xact(1'b0, 32'h10, 32'h0, 2, 3, 32'hDEADBEEF, 1'b0, "bp10");

      // Address wrap: 0x1000 aliases word 0
      xact(1'b1, 32'h1000, 32'h12345678, 2, 0, 32'h12345678, 1'b0, "wr1000");
      xact(1'b0, 32'h0, 32'h0, 2, 1, 32'h12345678, 1'b0, "rd0");

      // Reset in WAIT discards the write (LATENCY = 2)
      xact(1'b1, 32'h30, 32'h11112222, 2, 0, 32'h11112222, 1'b0, "wr30");
      abort_write(32'h30, 32'h55555555, 2, "abort30");
      xact(1'b0, 32'h30, 32'h0, 2, 0, 32'h11112222, 1'b0, "rd30");

      // Reset in RESP drops the response
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 32'h30;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("rresp_vld", resp_valid, 1);
      check("rresp_rdata", resp_rdata, 32'h11112222);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rresp_vld_drop", resp_valid, 0);
      check("rresp_rdata_rst", resp_rdata, 0);
      check("rresp_ready", req_ready, 1);
      @(posedge clk); #1;

      // LATENCY = 4 instance: reset mid-WAIT keeps prior contents
      sel = 1'b1;
      xact(1'b1, 32'h20, 32'h01020304, 4, 0, 32'h01020304, 1'b0, "l4_wr20");
      abort_write(32'h20, 32'hAAAA5555, 4, "l4_abort20");
      xact(1'b0, 32'h20, 32'h0, 4, 0, 32'h01020304, 1'b0, "l4_rd20");
      sel = 1'b0;
      #1;

      // Misaligned write
      xact(1'b1, 32'h20, 32'h0BADF00D, 2, 0, 32'h0BADF00D, 1'b0, "wr20");
`ifdef MEM_ALIGN_CHECK_EN
      xact(1'b1, 32'h22, 32'hFFFFFFFF, 2, 0, 32'h0, 1'b1, "wr22_mis");
      xact(1'b0, 32'h20, 32'h0, 2, 0, 32'h0BADF00D, 1'b0, "rd20_after");
`else
      xact(1'b1, 32'h22, 32'hFFFFFFFF, 2, 0, 32'hFFFFFFFF, 1'b0, "wr22_mis");
      xact(1'b0, 32'h20, 32'h0, 2, 0, 32'hFFFFFFFF, 1'b0, "rd20_after");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
